// File: rtl/memory1_stage.sv
// First memory pipeline stage: latches the execute result, checks load/store alignment and
// issues exactly one dcache request per memory instruction before handing off to Memory2.
package memory1_pkg;

    typedef enum logic [1:0] {
        BT_BYTE      = 2'd0,
        BT_HALF_WORD = 2'd1,
        BT_WORD      = 2'd2
    } byte_type_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_mem;
        logic        is_store;
        byte_type_e  byte_type;
        logic        is_signed;
        logic [31:0] ex_out;
        logic [31:0] st_data;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic [31:0] pc_plus4;
    } execute_memory1_pass_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_mem;
        logic        is_store;
        byte_type_e  byte_type;
        logic        is_signed;
        logic [1:0]  byte_en;
        logic        excp_ale;
        logic [31:0] ex_out;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic [31:0] pc_plus4;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] data;
    } forward_req_t;

endpackage

module memory1_stage
    import memory1_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  next_rdy_in,
    output logic                  rdy_in,
    input  execute_memory1_pass_t pass_in,
    output memory1_memory2_pass_t pass_out,
    output forward_req_t          fwd_req,
    output logic                  dcache_req,
    input  logic                  dcache_ready,
    output logic [31:0]           dcache_addr,
    output logic                  dcache_is_store,
    output logic [3:0]            dcache_wstrb,
    output logic [31:0]           dcache_wdata
);

    typedef enum logic {
        REQ_IDLE,
        REQ_DONE
    } req_state_e;

    req_state_e            state_q, state_d;
    execute_memory1_pass_t instr_q;

    logic [1:0] offset;
    logic       excpAle;
    logic       needReq;
    logic       reqStall;
    logic       m1Flush;
    logic       m1Stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q.valid <= 1'b0;
        end else if (rdy_in) begin
            instr_q <= pass_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE remembers that the dcache already took this instruction's request while it is stalled.
    always_comb begin
        offset   = instr_q.ex_out[1:0];
        excpAle  = instr_q.is_mem &
                   (((instr_q.byte_type == BT_HALF_WORD) & offset[0]) |
                    ((instr_q.byte_type == BT_WORD) & (offset != 2'b00)));
        needReq  = instr_q.valid & instr_q.is_mem & ~excpAle & ~flush;
        reqStall = needReq & ~dcache_ready & (state_q == REQ_IDLE);
        m1Flush  = flush | ~instr_q.valid;
        m1Stall  = ~next_rdy_in | reqStall;
        rdy_in   = m1Flush | ~m1Stall;

        dcache_req = 1'b0;
        state_d    = state_q;
        case (state_q)
            REQ_IDLE: begin
                dcache_req = needReq;
                if (needReq & dcache_ready & m1Stall) begin
                    state_d = REQ_DONE;
                end
            end
            REQ_DONE: begin
                if (rdy_in | flush) begin
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    always_comb begin
        dcache_addr     = instr_q.ex_out;
        dcache_is_store = instr_q.is_store;
        dcache_wstrb    = 4'b0000;
        dcache_wdata    = instr_q.st_data;
        case (instr_q.byte_type)
            BT_BYTE: begin
                if (instr_q.is_store) begin
                    dcache_wstrb = 4'b0001 << offset;
                end
                dcache_wdata = {4{instr_q.st_data[7:0]}};
            end
            BT_HALF_WORD: begin
                if (instr_q.is_store) begin
                    dcache_wstrb = offset[1] ? 4'b1100 : 4'b0011;
                end
                dcache_wdata = {2{instr_q.st_data[15:0]}};
            end
            default: begin
                if (instr_q.is_store) begin
                    dcache_wstrb = 4'b1111;
                end
            end
        endcase
    end

    // A misaligned access must not write the register file, so its forward is suppressed too.
    always_comb begin
        pass_out.valid             = ~m1Flush & ~m1Stall;
        pass_out.pc                = instr_q.pc;
        pass_out.inst              = instr_q.inst;
        pass_out.is_mem            = instr_q.is_mem;
        pass_out.is_store          = instr_q.is_store;
        pass_out.byte_type         = instr_q.byte_type;
        pass_out.is_signed         = instr_q.is_signed;
        pass_out.byte_en           = offset;
        pass_out.excp_ale          = excpAle;
        pass_out.ex_out            = instr_q.ex_out;
        pass_out.rd                = instr_q.rd;
        pass_out.is_wr_rd          = instr_q.is_wr_rd & ~excpAle;
        pass_out.is_wr_rd_pc_plus4 = instr_q.is_wr_rd_pc_plus4;
        pass_out.pc_plus4          = instr_q.pc_plus4;

        fwd_req.valid = instr_q.valid & instr_q.is_wr_rd & ~excpAle;
        fwd_req.idx   = instr_q.rd;
        fwd_req.data  = instr_q.is_wr_rd_pc_plus4 ? instr_q.pc_plus4 : instr_q.ex_out;
    end

endmodule

// File: tb/tb_memory1_stage.sv
// Testbench for memory1_stage: directed handshake scenarios plus a randomized scoreboard run.
module tb_memory1_stage;
    import memory1_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  flush;
    logic                  next_rdy_in;
    logic                  rdy_in;
    execute_memory1_pass_t pass_in;
    memory1_memory2_pass_t pass_out;
    forward_req_t          fwd_req;
    logic                  dcache_req;
    logic                  dcache_ready;
    logic [31:0]           dcache_addr;
    logic                  dcache_is_store;
    logic [3:0]            dcache_wstrb;
    logic [31:0]           dcache_wdata;

    memory1_stage dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .next_rdy_in     (next_rdy_in),
        .rdy_in          (rdy_in),
        .pass_in         (pass_in),
        .pass_out        (pass_out),
        .fwd_req         (fwd_req),
        .dcache_req      (dcache_req),
        .dcache_ready    (dcache_ready),
        .dcache_addr     (dcache_addr),
        .dcache_is_store (dcache_is_store),
        .dcache_wstrb    (dcache_wstrb),
        .dcache_wdata    (dcache_wdata)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  byteEn;
        logic        ale;
        logic        wrRd;
        logic        isStore;
        logic        fwdValid;
        logic [4:0]  fwdIdx;
        logic [31:0] fwdData;
    } expPass_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        isStore;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } expReq_t;

    expPass_t passQueue[$];
    expReq_t  reqQueue[$];
    int       checks = 0;
    int       errors = 0;
    logic     monitorOn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference model: access size in bytes, natural alignment, lane replication of store bytes.
    function automatic int accessSize(input byte_type_e bt);
        case (bt)
            BT_BYTE:      return 1;
            BT_HALF_WORD: return 2;
            default:      return 4;
        endcase
    endfunction

    function automatic logic isMisaligned(input execute_memory1_pass_t p);
        int n;
        int off;
        n   = accessSize(p.byte_type);
        off = int'(p.ex_out[1:0]);
        return p.is_mem && ((off % n) != 0);
    endfunction

    function automatic expPass_t modelPass(input execute_memory1_pass_t p);
        expPass_t e;
        logic     ale;
        ale        = isMisaligned(p);
        e.pc       = p.pc;
        e.byteEn   = 2'(p.ex_out % 4);
        e.ale      = ale;
        e.wrRd     = p.is_wr_rd && !ale;
        e.isStore  = p.is_store;
        e.fwdValid = p.is_wr_rd && !ale;
        e.fwdIdx   = p.rd;
        e.fwdData  = p.is_wr_rd_pc_plus4 ? (p.pc + 32'd4) : p.ex_out;
        return e;
    endfunction

    function automatic expReq_t modelReq(input execute_memory1_pass_t p);
        expReq_t r;
        int      n;
        int      off;
        n         = accessSize(p.byte_type);
        off       = int'(p.ex_out % 4);
        r.addr    = p.ex_out;
        r.isStore = p.is_store;
        r.wstrb   = p.is_store ? 4'(((1 << n) - 1) << off) : 4'd0;
        r.wdata   = '0;
        for (int b = 0; b < 4; b++) begin
            r.wdata[8*b +: 8] = p.st_data[8*(b % n) +: 8];
        end
        return r;
    endfunction

    function automatic execute_memory1_pass_t makeInstr(input logic [31:0] pc, input logic isMem,
                                                        input logic isStore, input byte_type_e bt,
                                                        input logic [31:0] addr, input logic [31:0] st,
                                                        input logic wrRd);
        execute_memory1_pass_t p;
        p                   = '0;
        p.valid             = 1'b1;
        p.pc                = pc;
        p.inst              = 32'h0000_0013;
        p.is_mem            = isMem;
        p.is_store          = isStore;
        p.byte_type         = bt;
        p.ex_out            = addr;
        p.st_data           = st;
        p.rd                = 5'd7;
        p.is_wr_rd          = wrRd;
        p.pc_plus4          = pc + 32'd4;
        return p;
    endfunction

    function automatic execute_memory1_pass_t randInstr(input int i);
        execute_memory1_pass_t p;
        p                   = '0;
        p.valid             = 1'b1;
        p.pc                = 32'h0000_4000 + 32'(i) * 32'd4;
        p.inst              = $urandom;
        p.is_mem            = ($urandom % 4) != 0;
        p.is_store          = p.is_mem && ($urandom % 2 == 0);
        p.byte_type         = byte_type_e'($urandom_range(0, 2));
        p.is_signed         = $urandom % 2 == 0;
        p.ex_out            = $urandom;
        p.st_data           = $urandom;
        p.rd                = 5'($urandom);
        p.is_wr_rd          = !p.is_store && ($urandom % 4 != 0);
        p.is_wr_rd_pc_plus4 = !p.is_mem && ($urandom % 3 == 0);
        p.pc_plus4          = p.pc + 32'd4;
        return p;
    endfunction

    task automatic nextDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic randomizeBackpressure();
        dcache_ready = ($urandom % 4) != 0;
        next_rdy_in  = ($urandom % 4) != 0;
    endtask

    // Holds an instruction on pass_in until the stage takes it, then records what must come out.
    task automatic applyStimulus(input execute_memory1_pass_t p);
        int waitCycles;
        waitCycles = 0;
        pass_in    = p;
        randomizeBackpressure();
        @(negedge clk);
        while (!rdy_in && waitCycles < 200) begin
            nextDrive();
            randomizeBackpressure();
            @(negedge clk);
            waitCycles++;
        end
        if (!rdy_in) begin
            checkOutput("acceptTimeout", 32'(waitCycles), 32'd0);
        end else begin
            passQueue.push_back(modelPass(p));
            if (p.is_mem && !isMisaligned(p)) begin
                reqQueue.push_back(modelReq(p));
            end
        end
        nextDrive();
        pass_in.valid = 1'b0;
    endtask

    task automatic loadOne(input execute_memory1_pass_t p);
        pass_in = p;
        nextDrive();
        pass_in.valid = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: every handoff to Memory2 and every accepted dcache request is matched in order.
    initial begin
        expPass_t ep;
        expReq_t  er;
        forever begin
            @(negedge clk);
            if (monitorOn) begin
                if (pass_out.valid) begin
                    if (passQueue.size() == 0) begin
                        checkOutput("unexpectedPassOut", pass_out.pc, 32'hFFFF_FFFF);
                    end else begin
                        ep = passQueue.pop_front();
                        checkOutput("passPc", pass_out.pc, ep.pc);
                        checkOutput("passByteEn", 32'(pass_out.byte_en), 32'(ep.byteEn));
                        checkOutput("passAle", 32'(pass_out.excp_ale), 32'(ep.ale));
                        checkOutput("passWrRd", 32'(pass_out.is_wr_rd), 32'(ep.wrRd));
                        checkOutput("passIsStore", 32'(pass_out.is_store), 32'(ep.isStore));
                        checkOutput("fwdValid", 32'(fwd_req.valid), 32'(ep.fwdValid));
                        checkOutput("fwdIdx", 32'(fwd_req.idx), 32'(ep.fwdIdx));
                        if (ep.fwdValid) begin
                            checkOutput("fwdData", fwd_req.data, ep.fwdData);
                        end
                    end
                end
                if (dcache_req && dcache_ready) begin
                    if (reqQueue.size() == 0) begin
                        checkOutput("unexpectedDcacheReq", dcache_addr, 32'hFFFF_FFFF);
                    end else begin
                        er = reqQueue.pop_front();
                        checkOutput("reqAddr", dcache_addr, er.addr);
                        checkOutput("reqIsStore", 32'(dcache_is_store), 32'(er.isStore));
                        checkOutput("reqWstrb", 32'(dcache_wstrb), 32'(er.wstrb));
                        if (er.isStore) begin
                            checkOutput("reqWdata", dcache_wdata, er.wdata);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int reqCycles;
        int stallCycles;
        int validCycles;
        int validAt;

        rst          = 1'b1;
        flush        = 1'b0;
        next_rdy_in  = 1'b1;
        dcache_ready = 1'b1;
        pass_in      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetPassValid", 32'(pass_out.valid), 32'd0);
        checkOutput("resetDcacheReq", 32'(dcache_req), 32'd0);
        checkOutput("resetRdyIn", 32'(rdy_in), 32'd1);
        checkOutput("resetFwdValid", 32'(fwd_req.valid), 32'd0);
        nextDrive();

        $display("[TB] aligned load");
        loadOne(makeInstr(32'h100, 1'b1, 1'b0, BT_WORD, 32'h1000, 32'h0, 1'b1));
        checkOutput("lwReq", 32'(dcache_req), 32'd1);
        checkOutput("lwAddr", dcache_addr, 32'h1000);
        checkOutput("lwIsStore", 32'(dcache_is_store), 32'd0);
        checkOutput("lwWstrb", 32'(dcache_wstrb), 32'd0);
        checkOutput("lwPassValid", 32'(pass_out.valid), 32'd1);
        checkOutput("lwByteEn", 32'(pass_out.byte_en), 32'd0);
        nextDrive();
        @(negedge clk);
        checkOutput("lwReqOneCycle", 32'(dcache_req), 32'd0);
        checkOutput("lwPassOneCycle", 32'(pass_out.valid), 32'd0);
        nextDrive();

        $display("[TB] byte and half-word stores");
        loadOne(makeInstr(32'h104, 1'b1, 1'b1, BT_BYTE, 32'h1003, 32'h0000_00AB, 1'b0));
        checkOutput("sbWstrb", 32'(dcache_wstrb), 32'h8);
        checkOutput("sbWdata", dcache_wdata, 32'hABAB_ABAB);
        checkOutput("sbIsStore", 32'(dcache_is_store), 32'd1);
        nextDrive();
        loadOne(makeInstr(32'h108, 1'b1, 1'b1, BT_HALF_WORD, 32'h1002, 32'h0000_1234, 1'b0));
        checkOutput("shWstrb", 32'(dcache_wstrb), 32'hC);
        checkOutput("shWdata", dcache_wdata, 32'h1234_1234);
        checkOutput("shByteEn", 32'(pass_out.byte_en), 32'd2);
        nextDrive();

        $display("[TB] dcache not ready for three cycles");
        dcache_ready = 1'b0;
        reqCycles = 0; stallCycles = 0; validCycles = 0;
        loadOne(makeInstr(32'h10C, 1'b1, 1'b0, BT_WORD, 32'h1000, 32'h0, 1'b1));
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) begin
                nextDrive();
                dcache_ready = (i >= 4);
                @(negedge clk);
            end
            reqCycles   += int'(dcache_req);
            stallCycles += int'(!rdy_in);
            validCycles += int'(pass_out.valid);
        end
        checkOutput("stallReqCycles", 32'(reqCycles), 32'd4);
        checkOutput("stallRdyLowCycles", 32'(stallCycles), 32'd3);
        checkOutput("stallValidCycles", 32'(validCycles), 32'd1);
        nextDrive();
        dcache_ready = 1'b1;

        $display("[TB] accepted request while Memory2 is busy");
        next_rdy_in = 1'b0;
        reqCycles = 0; validCycles = 0; validAt = 0;
        loadOne(makeInstr(32'h110, 1'b1, 1'b0, BT_WORD, 32'h2000, 32'h0, 1'b1));
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) begin
                nextDrive();
                next_rdy_in = (i >= 3);
                @(negedge clk);
            end
            reqCycles += int'(dcache_req);
            if (pass_out.valid) begin
                validCycles++;
                validAt = i;
            end
        end
        checkOutput("doneReqCycles", 32'(reqCycles), 32'd1);
        checkOutput("doneValidCycles", 32'(validCycles), 32'd1);
        checkOutput("doneValidAt", 32'(validAt), 32'd3);
        nextDrive();

        $display("[TB] misaligned load");
        dcache_ready = 1'b0;
        loadOne(makeInstr(32'h114, 1'b1, 1'b0, BT_WORD, 32'h1002, 32'h0, 1'b1));
        checkOutput("aleFlag", 32'(pass_out.excp_ale), 32'd1);
        checkOutput("aleNoReq", 32'(dcache_req), 32'd0);
        checkOutput("aleFwdValid", 32'(fwd_req.valid), 32'd0);
        checkOutput("alePassValid", 32'(pass_out.valid), 32'd1);
        checkOutput("aleRdyIn", 32'(rdy_in), 32'd1);
        checkOutput("aleWrRd", 32'(pass_out.is_wr_rd), 32'd0);
        nextDrive();

        $display("[TB] flush and reset during a stalled request");
        loadOne(makeInstr(32'h118, 1'b1, 1'b0, BT_WORD, 32'h3000, 32'h0, 1'b1));
        checkOutput("flushPreReq", 32'(dcache_req), 32'd1);
        checkOutput("flushPreRdy", 32'(rdy_in), 32'd0);
        nextDrive();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flushReq", 32'(dcache_req), 32'd0);
        checkOutput("flushRdy", 32'(rdy_in), 32'd1);
        checkOutput("flushPassValid", 32'(pass_out.valid), 32'd0);
        nextDrive();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flushGoneReq", 32'(dcache_req), 32'd0);
        nextDrive();
        loadOne(makeInstr(32'h11C, 1'b1, 1'b0, BT_WORD, 32'h3004, 32'h0, 1'b1));
        checkOutput("rstPreReq", 32'(dcache_req), 32'd1);
        nextDrive();
        rst = 1'b1;
        @(negedge clk);
        nextDrive();
        @(negedge clk);
        checkOutput("rstPassValid", 32'(pass_out.valid), 32'd0);
        checkOutput("rstReq", 32'(dcache_req), 32'd0);
        nextDrive();
        rst = 1'b0;
        dcache_ready = 1'b1;
        @(negedge clk);
        checkOutput("rstNoStaleReq", 32'(dcache_req), 32'd0);
        nextDrive();

        $display("[TB] randomized traffic");
        monitorOn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 4 == 0) begin
                pass_in.valid = 1'b0;
                randomizeBackpressure();
                nextDrive();
            end
            applyStimulus(randInstr(i));
        end
        pass_in.valid = 1'b0;
        dcache_ready  = 1'b1;
        next_rdy_in   = 1'b1;
        repeat (10) nextDrive();
        monitorOn = 1'b0;
        checkOutput("passQueueDrained", 32'(passQueue.size()), 32'd0);
        checkOutput("reqQueueDrained", 32'(reqQueue.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
